// File: rtl/load_store_unit.sv
// RV32I load/store unit: one req/gnt/rvalid data-memory access per request, LB/LH/LW/LBU/LHU/SB/SH/SW.
// Latency: 3 cycles accept-to-rsp_valid on a zero-wait bus, 1 cycle on misalign/illegal; LSU_TIMEOUT_EN adds a bus timeout.
// Backpressure: req_ready only in IDLE; waits on mem_gnt/mem_rvalid; no response backpressure.
module load_store_unit #(
    parameter int XLEN           = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                      clk,
    input  logic                      areset_n,
    input  logic                      req_valid,
    output logic                      req_ready,
    input  logic                      req_we,
    input  logic [2:0]                req_funct3,
    input  logic [XLEN-1:0]           req_addr,
    input  logic [XLEN-1:0]           req_wdata,
    input  logic [REG_ADDR_WIDTH-1:0] req_rd,
    output logic                      rsp_valid,
    output logic [XLEN-1:0]           rsp_rdata,
    output logic [REG_ADDR_WIDTH-1:0] rsp_rd,
    output logic                      rsp_err,
    output logic                      mem_req,
    input  logic                      mem_gnt,
    output logic                      mem_we,
    output logic [XLEN-1:0]           mem_addr,
    output logic [3:0]                mem_be,
    output logic [XLEN-1:0]           mem_wdata,
    input  logic                      mem_rvalid,
    input  logic [XLEN-1:0]           mem_rdata
);

    if (XLEN != 32 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("load_store_unit: XLEN must be 32 and TIMEOUT_CYCLES >= 1");
    end

    typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

    state_t          state_q, state_d;
    logic [2:0]      funct3_q;
    logic [1:0]      off_q;
    logic            err_q;
    logic            accept, legal, misalign, bad;
    logic            timeout, timeout_abort;
    logic [1:0]      size;
    logic [3:0]      be_d;
    logic [XLEN-1:0] wdata_d, rdata_sh, rdata_ext;

    assign accept = req_valid && req_ready;
    assign size   = req_funct3[1:0];

    always_comb begin
        legal    = req_we ? (req_funct3 inside {3'b000, 3'b001, 3'b010})
                          : (req_funct3 inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101});
        misalign = (size == 2'd1 && req_addr[0]) || (size == 2'd2 && req_addr[1:0] != 2'b00);
        bad      = !legal || misalign;
        case (size)
            2'd0:    begin be_d = 4'b0001 << req_addr[1:0]; wdata_d = {4{req_wdata[7:0]}};  end
            2'd1:    begin be_d = 4'b0011 << req_addr[1:0]; wdata_d = {2{req_wdata[15:0]}}; end
            default: begin be_d = 4'b1111;                  wdata_d = req_wdata;            end
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam int CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
    logic [CNT_W-1:0] cnt_q;

    // Any state change clears the counter, so it restarts on entry to both ADDR and DATA.
    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n)                              cnt_q <= '0;
        else if (state_d != state_q)                cnt_q <= '0;
        else if (state_q == ADDR || state_q == DATA) cnt_q <= cnt_q + CNT_W'(1);
    end

    assign timeout = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1));
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_d       = state_q;
        timeout_abort = 1'b0;
        case (state_q)
            IDLE: if (accept) state_d = bad ? RESP : ADDR;
            ADDR: begin
                if (mem_gnt)      state_d = DATA;
                else if (timeout) begin state_d = RESP; timeout_abort = 1'b1; end
            end
            DATA: begin
                if (mem_rvalid)   state_d = RESP;
                else if (timeout) begin state_d = RESP; timeout_abort = 1'b1; end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge areset_n) begin
        if (!areset_n) begin
            state_q   <= IDLE;
            funct3_q  <= 3'b000;
            off_q     <= 2'b00;
            err_q     <= 1'b0;
            rsp_rd    <= '0;
            rsp_rdata <= '0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_be    <= 4'b0000;
            mem_wdata <= '0;
        end else begin
            state_q <= state_d;
            if (accept) begin
                funct3_q  <= req_funct3;
                off_q     <= req_addr[1:0];
                err_q     <= bad;
                rsp_rd    <= req_rd;
                rsp_rdata <= '0;
                // Failed accesses leave the bus registers untouched so nothing partial is driven.
                if (!bad) begin
                    mem_we    <= req_we;
                    mem_addr  <= {req_addr[XLEN-1:2], 2'b00};
                    mem_be    <= be_d;
                    mem_wdata <= wdata_d;
                end
            end else if (timeout_abort) begin
                err_q <= 1'b1;
            end
            if (state_q == DATA && mem_rvalid && !mem_we) rsp_rdata <= rdata_ext;
        end
    end

    assign rdata_sh = mem_rdata >> {off_q, 3'b000};

    always_comb begin
        case (funct3_q)
            3'b000:  rdata_ext = {{(XLEN-8){rdata_sh[7]}},   rdata_sh[7:0]};
            3'b001:  rdata_ext = {{(XLEN-16){rdata_sh[15]}}, rdata_sh[15:0]};
            3'b100:  rdata_ext = {{(XLEN-8){1'b0}},          rdata_sh[7:0]};
            3'b101:  rdata_ext = {{(XLEN-16){1'b0}},         rdata_sh[15:0]};
            default: rdata_ext = rdata_sh;
        endcase
    end

    assign req_ready = (state_q == IDLE);
    assign rsp_valid = (state_q == RESP);
    assign rsp_err   = rsp_valid && err_q;
    assign mem_req   = (state_q == ADDR);

endmodule

// File: tb/tb_load_store_unit.sv
// Directed bench for load_store_unit: vector table for single accesses plus wait-state, reset and timeout sequences.
module tb_load_store_unit;

    logic        clk = 1'b0;
    logic        areset_n;
    logic        req_valid, req_ready, req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr, req_wdata;
    logic [4:0]  req_rd;
    logic        rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;
    logic [4:0]  rsp_rd;
    logic        mem_req, mem_gnt, mem_we, mem_rvalid;
    logic [31:0] mem_addr, mem_wdata, mem_rdata;
    logic [3:0]  mem_be;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    load_store_unit #(.XLEN(32), .REG_ADDR_WIDTH(5), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .areset_n(areset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata), .req_rd(req_rd),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_rd(rsp_rd), .rsp_err(rsp_err),
        .mem_req(mem_req), .mem_gnt(mem_gnt), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_be(mem_be), .mem_wdata(mem_wdata), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
    );

    typedef struct {
        logic        we;
        logic [2:0]  f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] rdata;
        logic        err;
        logic [3:0]  be;
        logic [31:0] maddr;
        logic [31:0] mwdata;
        logic [31:0] exp_rdata;
    } vec_t;

    vec_t vecs[13];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic present(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                           input logic [31:0] wdata, input logic [4:0] rd);
        req_valid = 1'b1; req_we = we; req_funct3 = f3;
        req_addr = addr; req_wdata = wdata; req_rd = rd;
        step();
        req_valid = 1'b0;
    endtask

    task automatic run_vec(input int i);
        vec_t v;
        v = vecs[i];
        present(v.we, v.f3, v.addr, v.wdata, 5'(i + 1));
        if (v.err) begin
            chk("err_rsp_valid", 32'(rsp_valid), 32'd1);
            chk("err_rsp_err", 32'(rsp_err), 32'd1);
            chk("err_no_mem_req", 32'(mem_req), 32'd0);
            chk("err_rdata", rsp_rdata, 32'd0);
            chk("err_rd", 32'(rsp_rd), 32'(i + 1));
        end else begin
            chk("addr_mem_req", 32'(mem_req), 32'd1);
            chk("addr_mem_addr", mem_addr, v.maddr);
            chk("addr_mem_be", 32'(mem_be), 32'(v.be));
            chk("addr_mem_we", 32'(mem_we), 32'(v.we));
            if (v.we) chk("addr_mem_wdata", mem_wdata, v.mwdata);
            chk("addr_no_rsp", 32'(rsp_valid), 32'd0);
            mem_gnt = 1'b1;
            step();
            mem_gnt = 1'b0;
            chk("data_mem_req_low", 32'(mem_req), 32'd0);
            chk("data_no_rsp", 32'(rsp_valid), 32'd0);
            mem_rvalid = 1'b1;
            mem_rdata  = v.rdata;
            step();
            mem_rvalid = 1'b0;
            chk("rsp_valid", 32'(rsp_valid), 32'd1);
            chk("rsp_err", 32'(rsp_err), 32'd0);
            chk("rsp_rdata", rsp_rdata, v.exp_rdata);
            chk("rsp_rd", 32'(rsp_rd), 32'(i + 1));
        end
        step();
        chk("rsp_one_cycle", 32'(rsp_valid), 32'd0);
        chk("ready_after_rsp", 32'(req_ready), 32'd1);
    endtask

    initial begin
        int edges;
        logic [31:0] hold_addr;
        logic [3:0]  hold_be;

        //           we    f3      addr          wdata         rdata        err   be       maddr         mwdata        exp_rdata
        vecs[0]  = '{1'b0, 3'b010, 32'h0000_0100, 32'h0,        32'hDEADBEEF, 1'b0, 4'b1111, 32'h0000_0100, 32'h0,        32'hDEADBEEF};
        vecs[1]  = '{1'b0, 3'b000, 32'h0000_0103, 32'h0,        32'h80FF0000, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'hFFFFFF80};
        vecs[2]  = '{1'b0, 3'b100, 32'h0000_0103, 32'h0,        32'h80FF0000, 1'b0, 4'b1000, 32'h0000_0100, 32'h0,        32'h00000080};
        vecs[3]  = '{1'b0, 3'b001, 32'h0000_0102, 32'h0,        32'h80FF0000, 1'b0, 4'b1100, 32'h0000_0100, 32'h0,        32'hFFFF80FF};
        vecs[4]  = '{1'b0, 3'b101, 32'h0000_0100, 32'h0,        32'h12348765, 1'b0, 4'b0011, 32'h0000_0100, 32'h0,        32'h00008765};
        vecs[5]  = '{1'b1, 3'b001, 32'h0000_0202, 32'h00001234, 32'hFFFFFFFF, 1'b0, 4'b1100, 32'h0000_0200, 32'h12341234, 32'h0};
        vecs[6]  = '{1'b1, 3'b000, 32'h0000_0301, 32'h000000AB, 32'hFFFFFFFF, 1'b0, 4'b0010, 32'h0000_0300, 32'hABABABAB, 32'h0};
        vecs[7]  = '{1'b1, 3'b010, 32'h0000_0404, 32'hCAFEF00D, 32'hFFFFFFFF, 1'b0, 4'b1111, 32'h0000_0404, 32'hCAFEF00D, 32'h0};
        vecs[8]  = '{1'b0, 3'b010, 32'h0000_0101, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
        vecs[9]  = '{1'b0, 3'b011, 32'h0000_0100, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
        vecs[10] = '{1'b1, 3'b001, 32'h0000_0203, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
        vecs[11] = '{1'b1, 3'b100, 32'h0000_0200, 32'h0,        32'h0,        1'b1, 4'b0000, 32'h0,         32'h0,        32'h0};
        vecs[12] = '{1'b0, 3'b000, 32'h0000_0101, 32'h0,        32'h00007F00, 1'b0, 4'b0010, 32'h0000_0100, 32'h0,        32'h0000007F};

        areset_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = '0; req_wdata = '0; req_rd = '0;
        mem_gnt = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
        #3;
        chk("rst_req_ready", 32'(req_ready), 32'd1);
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_rsp_err", 32'(rsp_err), 32'd0);
        chk("rst_mem_req", 32'(mem_req), 32'd0);
        chk("rst_mem_we", 32'(mem_we), 32'd0);
        chk("rst_mem_be", 32'(mem_be), 32'd0);
        chk("rst_rsp_rdata", rsp_rdata, 32'd0);
        chk("rst_rsp_rd", 32'(rsp_rd), 32'd0);
        chk("rst_mem_addr", mem_addr, 32'd0);
        chk("rst_mem_wdata", mem_wdata, 32'd0);
        step();
        areset_n = 1'b1;
        step();

        for (int i = 0; i < 13; i++) run_vec(i);

        // Delayed grant and read data, with a stray rvalid during ADDR that must be ignored.
        present(1'b0, 3'b010, 32'h0000_0108, 32'h0, 5'd20);
        edges = 0;
        hold_addr = mem_addr;
        hold_be   = mem_be;
        chk("ws_addr", hold_addr, 32'h0000_0108);
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h55555555;
        for (int c = 0; c < 3; c++) begin
            step(); edges++;
            chk("ws_req_held", 32'(mem_req), 32'd1);
            chk("ws_addr_stable", mem_addr, hold_addr);
            chk("ws_be_stable", 32'(mem_be), 32'(hold_be));
            chk("ws_we_stable", 32'(mem_we), 32'd0);
        end
        mem_rvalid = 1'b0;
        mem_gnt = 1'b1;
        step(); edges++;
        mem_gnt = 1'b0;
        chk("ws_req_drop", 32'(mem_req), 32'd0);
        for (int c = 0; c < 2; c++) begin
            step(); edges++;
            chk("ws_wait_rvalid", 32'(rsp_valid), 32'd0);
        end
        mem_rvalid = 1'b1;
        mem_rdata  = 32'h11223344;
        step(); edges++;
        mem_rvalid = 1'b0;
        chk("ws_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("ws_latency_edges", 32'(edges), 32'd7);
        chk("ws_rdata", rsp_rdata, 32'h11223344);
        step();

        // Reset during ADDR drops mem_req without waiting for a clock edge.
        present(1'b1, 3'b010, 32'h0000_0500, 32'h0BADF00D, 5'd21);
        chk("ra_req_before", 32'(mem_req), 32'd1);
        #2;
        areset_n = 1'b0;
        #1;
        chk("ra_req_async_drop", 32'(mem_req), 32'd0);
        chk("ra_be_cleared", 32'(mem_be), 32'd0);
        step();
        areset_n = 1'b1;
        step();
        chk("ra_ready", 32'(req_ready), 32'd1);

        // Reset during DATA abandons the access; a late rvalid in IDLE produces nothing.
        present(1'b0, 3'b010, 32'h0000_0600, 32'h0, 5'd22);
        mem_gnt = 1'b1;
        step();
        mem_gnt = 1'b0;
        #2;
        areset_n = 1'b0;
        #1;
        chk("rd_mem_req", 32'(mem_req), 32'd0);
        chk("rd_rsp_valid", 32'(rsp_valid), 32'd0);
        step();
        areset_n = 1'b1;
        mem_rvalid = 1'b1;
        mem_rdata  = 32'hFFFF_FFFF;
        for (int c = 0; c < 2; c++) begin
            step();
            chk("rd_no_rsp", 32'(rsp_valid), 32'd0);
            chk("rd_idle_ready", 32'(req_ready), 32'd1);
        end
        mem_rvalid = 1'b0;
        chk("rd_rdata_zero", rsp_rdata, 32'd0);

`ifdef LSU_TIMEOUT_EN
        present(1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd23);
        edges = 0;
        while (!rsp_valid && edges < 20) begin
            step(); edges++;
        end
        chk("to_rsp_valid", 32'(rsp_valid), 32'd1);
        chk("to_addr_cycles", 32'(edges), 32'd4);
        chk("to_rsp_err", 32'(rsp_err), 32'd1);
        chk("to_rdata", rsp_rdata, 32'd0);
        chk("to_mem_req", 32'(mem_req), 32'd0);
        step();
        chk("to_ready", 32'(req_ready), 32'd1);
`else
        present(1'b0, 3'b010, 32'h0000_0700, 32'h0, 5'd23);
        for (int c = 0; c < 10; c++) begin
            step();
            chk("nt_still_waiting", 32'(mem_req), 32'd1);
            chk("nt_no_rsp", 32'(rsp_valid), 32'd0);
        end
        areset_n = 1'b0;
        step();
        areset_n = 1'b1;
        step();
        chk("nt_ready", 32'(req_ready), 32'd1);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
